// File: rtl/pwm_ramp_ctrl.sv
// Per-channel duty sequencer: ramps each live duty toward its target by STEP on every prescaler tick.
// Registers written over a byte-wide bus; read data is combinational, duty/busy/done are registered.
module pwm_ramp_ctrl #(
  parameter int CHANNELS = 3,
  parameter int DUTY_W   = 8,
  parameter int PRESC_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         nrst_i,
  input  logic                         cfg_we_i,
  input  logic [7:0]                   cfg_addr_i,
  input  logic [7:0]                   cfg_data_i,
  output logic [7:0]                   cfg_rdata_o,
  output logic [CHANNELS*DUTY_W-1:0]   duty_o,
  output logic [CHANNELS-1:0]          busy_o,
  output logic [CHANNELS-1:0]          done_o,
  output logic                         tick_o
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] cnt_q;
  logic               run_q;
  logic               tick;
  logic               wr_presc_lo;
  logic               wr_presc_hi;

  logic [DUTY_W-1:0]  target_q [CHANNELS];
  logic [DUTY_W-1:0]  step_q   [CHANNELS];
  logic [DUTY_W-1:0]  duty_q   [CHANNELS];
  logic [CHANNELS-1:0] busy_q;
  logic [CHANNELS-1:0] done_q;

  logic [CHANNELS-1:0] wr_tgt;
  logic [CHANNELS-1:0] wr_step;
  logic [CHANNELS-1:0] ramp_hit;
  logic [DUTY_W-1:0]   ramp_nxt [CHANNELS];

  // run_q holds the counter at zero for the first cycle out of reset so tick_o stays low in reset.
  assign tick        = run_q && (cnt_q == presc_q);
  assign tick_o      = tick;
  assign wr_presc_lo = cfg_we_i && (cfg_addr_i == 8'h00);
  assign wr_presc_hi = cfg_we_i && (cfg_addr_i == 8'h01);
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      presc_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (wr_presc_lo) presc_q[7:0]  <= cfg_data_i;
      if (wr_presc_hi) presc_q[15:8] <= cfg_data_i;
      if (wr_presc_lo || wr_presc_hi || !run_q || tick) cnt_q <= '0;
      else                                              cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    wr_tgt  = '0;
    wr_step = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      wr_tgt[k]  = cfg_we_i && (cfg_addr_i == 8'(2 + 2*k));
      wr_step[k] = cfg_we_i && (cfg_addr_i == 8'(3 + 2*k));
    end
  end

  // Distance is taken in 9 bits so the sign picks direction; a hit clamps onto the target.
  always_comb begin
    logic [DUTY_W:0] sdiff;
    logic [DUTY_W:0] mag;
    sdiff    = '0;
    mag      = '0;
    ramp_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sdiff       = {1'b0, target_q[k]} - {1'b0, duty_q[k]};
      mag         = sdiff[DUTY_W] ? ((DUTY_W+1)'(0) - sdiff) : sdiff;
      ramp_hit[k] = (step_q[k] == '0) || (mag <= {1'b0, step_q[k]});
      ramp_nxt[k] = sdiff[DUTY_W] ? (duty_q[k] - step_q[k]) : (duty_q[k] + step_q[k]);
    end
  end

  // A target write in the same cycle as a tick takes priority; that channel skips the tick.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        target_q[k] <= '0;
        step_q[k]   <= DUTY_W'(1);
        duty_q[k]   <= '0;
      end
      busy_q <= '0;
      done_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        done_q[k] <= 1'b0;
        if (wr_tgt[k]) begin
          target_q[k] <= cfg_data_i;
          if (cfg_data_i == duty_q[k]) begin
            busy_q[k] <= 1'b0;
            done_q[k] <= 1'b1;
          end else if (step_q[k] == '0) begin
            duty_q[k] <= cfg_data_i;
            busy_q[k] <= 1'b0;
            done_q[k] <= 1'b1;
          end else begin
            busy_q[k] <= 1'b1;
          end
        end else if (tick && busy_q[k]) begin
          if (ramp_hit[k]) begin
            duty_q[k] <= target_q[k];
            busy_q[k] <= 1'b0;
            done_q[k] <= 1'b1;
          end else begin
            duty_q[k] <= ramp_nxt[k];
          end
        end
        if (wr_step[k]) step_q[k] <= cfg_data_i;
      end
    end
  end

  always_comb begin
    duty_o = '0;
    for (int k = 0; k < CHANNELS; k++) duty_o[k*DUTY_W +: DUTY_W] = duty_q[k];
  end

  always_comb begin
    cfg_rdata_o = '0;
    if (cfg_addr_i == 8'h00) cfg_rdata_o = presc_q[7:0];
    if (cfg_addr_i == 8'h01) cfg_rdata_o = presc_q[15:8];
    for (int k = 0; k < CHANNELS; k++) begin
      if (cfg_addr_i == 8'(2 + 2*k)) cfg_rdata_o = target_q[k];
      if (cfg_addr_i == 8'(3 + 2*k)) cfg_rdata_o = step_q[k];
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: register map, ramp sequences, retarget, tick collision and reset abort.
module tb_pwm_ramp_ctrl;
  localparam int CH = 3;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          we = 1'b0;
  logic [7:0]    addr = 8'h00;
  logic [7:0]    data = 8'h00;
  logic [7:0]    rdata;
  logic [CH*8-1:0] duty;
  logic [CH-1:0] busy;
  logic [CH-1:0] done;
  logic          tick;

  int checks = 0;
  int errors = 0;

  pwm_ramp_ctrl #(.CHANNELS(CH), .DUTY_W(8), .PRESC_W(16)) dut (
    .clk_i(clk), .nrst_i(nrst), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_data_i(data),
    .cfg_rdata_o(rdata), .duty_o(duty), .busy_o(busy), .done_o(done), .tick_o(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d2;
    logic       last0;
    logic       last2;
  } pair_vec_t;

  rd_vec_t   rd_tbl [9];
  pair_vec_t pair_tbl [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] duty_of(input int ch);
    return duty[ch*8 +: 8];
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; data = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (tick !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no tick within %0d cycles", n);
    end
  endtask

  task automatic step_chk(input int ch, input logic [7:0] exp, input logic last);
    int n;
    wait_tick(n);
    @(negedge clk);
    chk($sformatf("duty%0d", ch), duty_of(ch), exp);
    chk($sformatf("busy%0d", ch), busy[ch], !last);
    chk($sformatf("done%0d", ch), done[ch], last);
  endtask

  initial begin
    int n;
    rd_tbl[0] = '{8'h00, 8'h00}; rd_tbl[1] = '{8'h01, 8'h00};
    rd_tbl[2] = '{8'h02, 8'h00}; rd_tbl[3] = '{8'h03, 8'h01};
    rd_tbl[4] = '{8'h04, 8'h00}; rd_tbl[5] = '{8'h05, 8'h01};
    rd_tbl[6] = '{8'h06, 8'h00}; rd_tbl[7] = '{8'h07, 8'h01};
    rd_tbl[8] = '{8'h08, 8'h00};
    pair_tbl[0] = '{8'h40, 8'h10, 1'b0, 1'b0};
    pair_tbl[1] = '{8'h60, 8'h20, 1'b0, 1'b0};
    pair_tbl[2] = '{8'h80, 8'h30, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    nrst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      addr = rd_tbl[i].a;
      #1;
      chk($sformatf("rd_%02h", rd_tbl[i].a), rdata, rd_tbl[i].exp);
    end
    @(negedge clk);
    wr(8'h08, 8'h55);
    addr = 8'h08;
    #1 chk("rd_oob_after_wr", rdata, 0);
    @(negedge clk);

    // Upward ramp on ch0 with PRESC=3
    wr(8'h00, 8'h03);
    wr(8'h01, 8'h00);
    wait_tick(n);
    chk("presc_first_gap", n, 3);
    @(negedge clk);
    wait_tick(n);
    chk("presc_gap", n, 3);
    wr(8'h03, 8'h10);
    wr(8'h02, 8'h40);
    chk("busy0_start", busy[0], 1);
    chk("done0_start", done[0], 0);
    step_chk(0, 8'h10, 1'b0);
    step_chk(0, 8'h20, 1'b0);
    step_chk(0, 8'h30, 1'b0);
    step_chk(0, 8'h40, 1'b1);
    @(negedge clk);
    chk("done0_single", done[0], 0);
    addr = 8'h02;
    #1 chk("rd_target0", rdata, 8'h40);
    @(negedge clk);

    // Downward ramp on ch1 with clamp at the end
    wr(8'h05, 8'h00);
    wr(8'h04, 8'hF0);
    chk("jump_duty1", duty_of(1), 8'hF0);
    chk("jump_done1", done[1], 1);
    chk("jump_busy1", busy[1], 0);
    wr(8'h05, 8'h30);
    wr(8'h04, 8'h05);
    chk("busy1_start", busy[1], 1);
    step_chk(1, 8'hC0, 1'b0);
    step_chk(1, 8'h90, 1'b0);
    step_chk(1, 8'h60, 1'b0);
    step_chk(1, 8'h30, 1'b0);
    step_chk(1, 8'h05, 1'b1);
    @(negedge clk);
    chk("done1_single", done[1], 0);

    // Retarget mid-ramp reverses direction
    wr(8'h03, 8'h20);
    wr(8'h02, 8'hFF);
    step_chk(0, 8'h60, 1'b0);
    wr(8'h02, 8'h00);
    chk("retgt_done0", done[0], 0);
    chk("retgt_busy0", busy[0], 1);
    chk("retgt_duty0", duty_of(0), 8'h60);
    step_chk(0, 8'h40, 1'b0);
    step_chk(0, 8'h20, 1'b0);
    step_chk(0, 8'h00, 1'b1);
    @(negedge clk);
    chk("retgt_done0_single", done[0], 0);

    // TARGET2 write lands on the tick cycle: ch0 updates, ch2 waits
    wr(8'h07, 8'h10);
    wr(8'h02, 8'h80);
    wait_tick(n);
    wr(8'h06, 8'h30);
    chk("coll_duty0", duty_of(0), 8'h20);
    chk("coll_duty2", duty_of(2), 8'h00);
    chk("coll_busy2", busy[2], 1);
    chk("coll_done2", done[2], 0);
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      @(negedge clk);
      chk($sformatf("pair_duty0_%0d", i), duty_of(0), pair_tbl[i].d0);
      chk($sformatf("pair_duty2_%0d", i), duty_of(2), pair_tbl[i].d2);
      chk($sformatf("pair_done0_%0d", i), done[0], pair_tbl[i].last0);
      chk($sformatf("pair_done2_%0d", i), done[2], pair_tbl[i].last2);
      chk($sformatf("pair_busy2_%0d", i), busy[2], !pair_tbl[i].last2);
    end

    // Target equal to current duty completes at once
    wr(8'h02, 8'h80);
    chk("eq_done0", done[0], 1);
    chk("eq_busy0", busy[0], 0);
    chk("eq_duty0", duty_of(0), 8'h80);
    @(negedge clk);
    chk("eq_done0_single", done[0], 0);

    // Asynchronous reset in the middle of a ch1 ramp
    wr(8'h04, 8'hF5);
    step_chk(1, 8'h35, 1'b0);
    #2 nrst = 1'b0;
    #1;
    chk("arst_duty", duty, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_tick", tick, 0);
    @(negedge clk);
    chk("arst_done_hold", done, 0);
    addr = 8'h00;
    #1 chk("arst_presc", rdata, 0);
    addr = 8'h05;
    #1 chk("arst_step1", rdata, 8'h01);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Duty-cycle sequencer between the SPI register bus and the PWM channel array. Holds a per-channel target duty and step size, then ramps each live duty value toward its target on a programmable prescaler tick. Provides smooth fades without SPI traffic per step. Reports per-channel busy state and a completion pulse.

Parameters:
CHANNELS, 3, number of PWM channels driven (1..63)
DUTY_W, 8, duty value width; fixed at 8 to match the bus data width
PRESC_W, 16, prescaler reload width; occupies two 8-bit registers

Ports:
clk_i  input  1  system clock
nrst_i  input  1  reset; asynchronous, active-low
cfg_we_i  input  1  one-cycle register write strobe, synchronous to clk_i
cfg_addr_i  input  8  register address
cfg_data_i  input  8  write data
cfg_rdata_o  output  8  combinational read data for cfg_addr_i
duty_o  output  CHANNELS*8  live duty values; channel k at bits [8k+7:8k]
busy_o  output  CHANNELS  channel k is ramping
done_o  output  CHANNELS  one-cycle pulse when channel k reaches its target
tick_o  output  1  one-cycle prescaler tick (debug/observability)

Behaviour:
- Register map:
  - 0x00: PRESC[7:0].
  - 0x01: PRESC[15:8].
  - 0x02+2k: TARGET[k].
  - 0x03+2k: STEP[k].
  - Addresses >= 0x02+2*CHANNELS: reads return 0; writes are ignored.
- Reset (nrst_i low, asynchronous):
  - PRESC=0, prescaler counter=0.
  - All TARGET=0, all duty=0, all STEP=1.
  - busy_o=0, done_o=0, tick_o=0.
- Prescaler:
  - Counter increments every clk_i cycle.
  - When counter==PRESC: tick_o=1 for that cycle, and the counter returns to 0.
  - PRESC=0 gives a tick every cycle.
  - A write to 0x00 or 0x01 clears the counter. The next tick occurs PRESC+1 cycles after the write.
- TARGET[k] write, in the cycle after the strobe:
  - If data==duty[k]: busy[k]=0, and done[k] pulses once.
  - Else if STEP[k]==0: duty[k]=data immediately, busy[k]=0, and done[k] pulses.
  - Else: busy[k]=1. Ramping starts at the next tick.
- Ramp, on each tick for each channel with busy[k]=1:
  - d = |TARGET[k] - duty[k]|.
  - If d <= STEP[k]: duty[k]=TARGET[k], busy[k]=0, and done[k] pulses in the same update.
  - Otherwise duty[k] moves by STEP[k] toward the target.
  - Arithmetic is 9-bit internally. The duty value never wraps, overshoots or undershoots.
- Retarget while busy: the new TARGET takes effect immediately. The ramp continues from the current duty, with direction recomputed. No done pulse is issued for the abandoned target.
- STEP[k] write while busy: the new step applies from the next tick.
- Same-cycle TARGET[k] write and tick:
  - The write wins.
  - Channel k skips that tick's update; other channels update normally.
- Registers update only on cfg_we_i. A held-high strobe rewrites each cycle; no edge detection is performed.
- duty_o is registered. Latency from the tick cycle to the new duty_o value is 1 clk_i.
- Reset asserted mid-ramp aborts immediately to the reset values above. No done pulse is issued.

Test Plan:
- Reset, then read 0x00..0x07 -> PRESC=0x00/0x00; TARGET0=0x00, STEP0=0x01; CH1/CH2 likewise. Addr 0x08 reads 0x00. All outputs 0.
- PRESC=3, STEP0=0x10, TARGET0=0x40 -> duty0 steps 0x10, 0x20, 0x30, 0x40 on ticks 4 cycles apart. busy0 high throughout; done0 pulses once with the 0x40 update; busy0 drops.
- duty1=0xF0 (via STEP1=0 jump), then STEP1=0x30, TARGET1=0x05 -> duty1 steps 0xC0, 0x90, 0x60, 0x30, then 0x05 (clamped, d=0x2B<0x30). done1 pulses once. No wrap below 0.
- Ramp ch0 toward 0xFF with step 0x20. At duty0=0x60 write TARGET0=0x00 -> direction reverses: 0x40, 0x20, 0x00. Single done0 pulse at 0x00.
- TARGET2 write coincident with a tick while ch0 is ramping -> ch0 updates on that tick; ch2 unchanged that tick and ramps from the next tick.
- TARGET0=duty0 -> done0 pulses one cycle later, busy0 stays 0. Assert nrst_i mid-ramp on ch1 -> duty1=0, busy1=0 asynchronously, no done1 pulse.
